config_frame_writer: RTL and testbench

Downstream stage of the serial JTAG configuration receiver. Consumes the 32-bit word stream and its one-cycle word strobe, parses a header word, then assembles `NUM_ROWS` payload words into one configuration frame. On completion it drives the fabric frame-data bus and pulses exactly one bit of the one-hot frame-strobe bus, selected by the column and frame index in the header. Holds the written frame stable for the fabric latches.

---
 rtl/config_frame_pkg.sv | 20 ++
 rtl/frame_strobe_decoder.sv | 30 +++
 rtl/config_frame_writer.sv | 154 +++++++++++++++
 tb/tb_config_frame_writer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/config_frame_pkg.sv
// Shared definitions for the configuration frame writer: header layout,
// opcodes and the writer's state encoding.
package config_frame_pkg;

  localparam logic [7:0] OP_NOP         = 8'h00;
  localparam logic [7:0] OP_WRITE_FRAME = 8'h01;

  // Header fields are byte-wide; positions are the LSB of each field.
  localparam int FIELD_W    = 8;
  localparam int OPCODE_LSB = 24;
  localparam int COLUMN_LSB = 16;
  localparam int FRAME_LSB  = 8;

  typedef enum logic [1:0] {
    HEADER  = 2'd0,
    PAYLOAD = 2'd1,
    DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Maps a (column, frame) pair onto one bit of the flattened frame-strobe
// bus. Purely combinational; the parent registers the result.
module frame_strobe_decoder #(
  parameter int NUM_COLS           = 16,
  parameter int MAX_FRAMES_PER_COL = 20,
  parameter int IDX_W              = $clog2(NUM_COLS * MAX_FRAMES_PER_COL)
) (
  input  logic [IDX_W-1:0]                           col_i,
  input  logic [IDX_W-1:0]                           frame_i,
  input  logic                                       en_i,
  output logic [NUM_COLS*MAX_FRAMES_PER_COL-1:0]     strobe_o
);

  localparam int                NUM_STROBES = NUM_COLS * MAX_FRAMES_PER_COL;
  localparam logic [IDX_W-1:0]  FRAMES      = IDX_W'(MAX_FRAMES_PER_COL);

  logic [IDX_W-1:0] idx;

  assign idx = col_i * FRAMES + frame_i;

  // NOTE: strobe_o gets a default before the loop so every path assigns it;
  // without that, a purely combinational block would infer latches.
  always_comb begin
    strobe_o = '0;
    for (int i = 0; i < NUM_STROBES; i++) begin
      if (en_i && idx == IDX_W'(i)) strobe_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/config_frame_writer.sv
// Parses configuration headers from the upstream word stream, assembles
// NUM_ROWS payload words into a frame and strobes it into the fabric.
module config_frame_writer
  import config_frame_pkg::*;
#(
  parameter int NUM_ROWS           = 16,
  parameter int NUM_COLS           = 16,
  parameter int MAX_FRAMES_PER_COL = 20
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [31:0]                            word_in,
  input  logic                                   word_strobe,
  input  logic                                   config_done,
  output logic [NUM_ROWS*32-1:0]                 frame_data,
  output logic [NUM_COLS*MAX_FRAMES_PER_COL-1:0] frame_strobe,
  output logic                                   busy,
  output logic                                   header_error,
  output logic [15:0]                            frame_count
);

  localparam int NUM_STROBES = NUM_COLS * MAX_FRAMES_PER_COL;
  localparam int IDX_W       = (NUM_STROBES > 1) ? $clog2(NUM_STROBES) : 1;
  localparam int CNT_W       = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_ROWS - 1);

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              word_cnt_q, word_cnt_d;
  logic [IDX_W-1:0]              col_q, col_d;
  logic [IDX_W-1:0]              frame_q, frame_d;
  logic [NUM_ROWS-1:0][31:0]     buf_q, buf_d;
  logic [NUM_ROWS-1:0][31:0]     frame_data_q, frame_data_d;
  logic [NUM_STROBES-1:0]        frame_strobe_q, frame_strobe_d;
  logic                          busy_q, busy_d;
  logic                          header_error_q, header_error_d;
  logic [15:0]                   frame_count_q, frame_count_d;

  logic [FIELD_W-1:0]            hdr_opcode, hdr_col, hdr_frame;
  logic                          hdr_write_ok;
  logic                          frame_complete;
  logic [NUM_STROBES-1:0]        strobe_dec;

  assign hdr_opcode = word_in[OPCODE_LSB +: FIELD_W];
  assign hdr_col    = word_in[COLUMN_LSB +: FIELD_W];
  assign hdr_frame  = word_in[FRAME_LSB  +: FIELD_W];

  assign hdr_write_ok = (hdr_opcode == OP_WRITE_FRAME)
                     && (int'(hdr_col)   < NUM_COLS)
                     && (int'(hdr_frame) < MAX_FRAMES_PER_COL);

  // config_done takes priority, so a word arriving with it never completes.
  assign frame_complete = (state_q == PAYLOAD) && word_strobe && !config_done
                       && (word_cnt_q == LAST_WORD);

  frame_strobe_decoder #(
    .NUM_COLS           (NUM_COLS),
    .MAX_FRAMES_PER_COL (MAX_FRAMES_PER_COL),
    .IDX_W              (IDX_W)
  ) u_strobe_dec (
    .col_i    (col_q),
    .frame_i  (frame_q),
    .en_i     (frame_complete),
    .strobe_o (strobe_dec)
  );

  always_comb begin
    state_d        = state_q;
    word_cnt_d     = word_cnt_q;
    col_d          = col_q;
    frame_d        = frame_q;
    buf_d          = buf_q;
    frame_data_d   = frame_data_q;
    frame_strobe_d = '0;
    header_error_d = header_error_q;
    frame_count_d  = frame_count_q;

    if (config_done) begin
      state_d = DONE;
    end else begin
      unique case (state_q)
        HEADER: begin
          if (word_strobe) begin
            if (hdr_write_ok) begin
              state_d    = PAYLOAD;
              col_d      = IDX_W'(hdr_col);
              frame_d    = IDX_W'(hdr_frame);
              word_cnt_d = '0;
            end else if (hdr_opcode != OP_NOP) begin
              header_error_d = 1'b1;
            end
          end
        end
        PAYLOAD: begin
          if (word_strobe) begin
            // First payload word lands in the top row, last in row 0.
            buf_d[LAST_WORD - word_cnt_q] = word_in;
            if (word_cnt_q == LAST_WORD) begin
              frame_data_d    = buf_q;
              frame_data_d[0] = word_in;
              frame_strobe_d  = strobe_dec;
              if (frame_count_q != 16'hFFFF) frame_count_d = frame_count_q + 16'd1;
              state_d = HEADER;
            end else begin
              word_cnt_d = word_cnt_q + CNT_W'(1);
            end
          end
        end
        DONE:    state_d = DONE;
        default: state_d = HEADER;
      endcase
    end

    busy_d = (state_d == PAYLOAD);
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= HEADER;
      word_cnt_q     <= '0;
      col_q          <= '0;
      frame_q        <= '0;
      frame_data_q   <= '0;
      frame_strobe_q <= '0;
      busy_q         <= 1'b0;
      header_error_q <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      word_cnt_q     <= word_cnt_d;
      col_q          <= col_d;
      frame_q        <= frame_d;
      frame_data_q   <= frame_data_d;
      frame_strobe_q <= frame_strobe_d;
      busy_q         <= busy_d;
      header_error_q <= header_error_d;
      frame_count_q  <= frame_count_d;
    end
  end

  // NOTE: the assembly buffer is deliberately left out of reset: every row is
  // rewritten before a frame can complete, so its contents are never exposed.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign frame_data   = frame_data_q;
  assign frame_strobe = frame_strobe_q;
  assign busy         = busy_q;
  assign header_error = header_error_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_config_frame_writer.sv
// Directed bench for config_frame_writer: a queue-based frame model checked
// every cycle, plus literal expectations for the documented scenarios.
module tb_config_frame_writer;

  localparam int NR = 4;
  localparam int NC = 3;
  localparam int MF = 20;
  localparam int NS = NC * MF;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       word_in = '0;
  logic              word_strobe = 1'b0;
  logic              config_done = 1'b0;
  logic [NR*32-1:0]  frame_data;
  logic [NS-1:0]     frame_strobe;
  logic              busy;
  logic              header_error;
  logic [15:0]       frame_count;

  int n_checks = 0;
  int n_errors = 0;

  config_frame_writer #(
    .NUM_ROWS           (NR),
    .NUM_COLS           (NC),
    .MAX_FRAMES_PER_COL (MF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .word_in      (word_in),
    .word_strobe  (word_strobe),
    .config_done  (config_done),
    .frame_data   (frame_data),
    .frame_strobe (frame_strobe),
    .busy         (busy),
    .header_error (header_error),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  // Model state: what the outputs must be after the most recent edge.
  bit              model_valid = 1'b0;
  bit              m_done, m_in_frame, m_busy, m_err;
  int              m_col, m_frm;
  logic [31:0]     m_words[$];
  logic [NR*32-1:0] m_data;
  logic [NS-1:0]   m_strobe;
  logic [15:0]     m_count;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic d, input logic s, input logic [31:0] w);
    m_strobe = '0;
    if (r) begin
      model_valid = 1'b1;
      m_done = 0; m_in_frame = 0; m_busy = 0; m_err = 0;
      m_words.delete();
      m_data = '0; m_count = '0;
      return;
    end
    if (m_done) return;
    if (d) begin
      m_done = 1; m_in_frame = 0; m_busy = 0;
      return;
    end
    if (!s) return;
    if (!m_in_frame) begin
      if (w[31:24] == 8'h01 && int'(w[23:16]) < NC && int'(w[15:8]) < MF) begin
        m_in_frame = 1; m_busy = 1;
        m_col = int'(w[23:16]);
        m_frm = int'(w[15:8]);
        m_words.delete();
      end else if (w[31:24] != 8'h00) begin
        m_err = 1;
      end
    end else begin
      m_words.push_back(w);
      if (m_words.size() == NR) begin
        m_data = '0;
        foreach (m_words[i]) m_data = (m_data << 32) | (NR*32)'(m_words[i]);
        m_strobe = NS'(1) << (m_col * MF + m_frm);
        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
        m_in_frame = 0; m_busy = 0;
      end
    end
  endtask

  // One clock: drive on the falling edge, advance the model on the rising edge.
  task automatic cycle(input logic r, input logic d, input logic s, input logic [31:0] w);
    @(negedge clk);
    reset = r; config_done = d; word_strobe = s; word_in = w;
    @(posedge clk);
    model_step(r, d, s, w);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic send(input logic [31:0] w);
    cycle(1'b0, 1'b0, 1'b1, w);
  endtask

  task automatic send_frame(input logic [31:0] hdr, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
    send(hdr); send(w0); send(w1); send(w2); send(w3);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        check("frame_data",   128'(frame_data),   128'(m_data));
        check("frame_strobe", 128'(frame_strobe), 128'(m_strobe));
        check("busy",         128'(busy),         128'(m_busy));
        check("header_error", 128'(header_error), 128'(m_err));
        check("frame_count",  128'(frame_count),  128'(m_count));
      end
    end
  end

  initial begin
    do_reset(); do_reset();
    #1;
    check("rst_data",  128'(frame_data),  128'h0);
    check("rst_count", 128'(frame_count), 128'h0);

    // Single frame to column 2, frame 5 -> bit 45.
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    send(32'h0102_0500);
    #1 check("s1_busy", 128'(busy), 128'h1);
    send(32'h1111_1111); send(32'h2222_2222); send(32'h3333_3333); send(32'h4444_4444);
    #1;
    check("s1_data",   128'(frame_data),   128'h11111111_22222222_33333333_44444444);
    check("s1_strobe", 128'(frame_strobe), 128'(NS'(1) << 45));
    check("s1_count",  128'(frame_count),  128'h1);
    check("s1_busy0",  128'(busy),         128'h0);
    idle();
    #1 check("s1_pulse", 128'(frame_strobe), 128'h0);

    // Back-to-back frames: col 0 frame 0, then col 2 frame 19.
    do_reset();
    send_frame(32'h0100_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004);
    #1 check("s2_strobe0", 128'(frame_strobe), 128'h1);
    send_frame(32'h0102_1300, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003, 32'hB000_0004);
    #1;
    check("s2_strobe59", 128'(frame_strobe), 128'(NS'(1) << 59));
    check("s2_data",     128'(frame_data),   128'hB0000001_B0000002_B0000003_B0000004);
    check("s2_count",    128'(frame_count),  128'h2);
    idle();

    // Invalid headers, boundary frame index, then a valid frame (col 1 frame 2 -> bit 22).
    do_reset();
    send(32'h0103_0000);
    #1 check("s3_err", 128'(header_error), 128'h1);
    send(32'h7F00_0000);
    send(32'h0100_1400);
    #1 check("s3_busy", 128'(busy), 128'h0);
    send_frame(32'h0101_0200, 32'hC1, 32'hC2, 32'hC3, 32'hC4);
    #1;
    check("s3_strobe", 128'(frame_strobe), 128'(NS'(1) << 22));
    check("s3_sticky", 128'(header_error), 128'h1);
    idle();

    // NOPs between frames, with gaps inside the payload.
    do_reset();
    send(32'h0000_0000);
    send(32'h0100_0300);
    send(32'hD1); idle(); send(32'hD2); idle(); idle(); send(32'hD3); send(32'hD4);
    send(32'h0000_0000);
    send_frame(32'h0102_0000, 32'hE1, 32'hE2, 32'hE3, 32'hE4);
    #1 check("s4_noerr", 128'(header_error), 128'h0);
    idle();

    // config_done after 2 of 4 words: partial frame discarded, then terminal.
    do_reset();
    send_frame(32'h0100_0100, 32'hF1, 32'hF2, 32'hF3, 32'hF4);
    send(32'h0101_0300); send(32'h5555_5555); send(32'h6666_6666);
    cycle(1'b0, 1'b1, 1'b1, 32'h7777_7777);
    cycle(1'b0, 1'b1, 1'b1, 32'h8888_8888);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    send_frame(32'h0100_0000, 32'h1, 32'h2, 32'h3, 32'h4);
    #1;
    check("s5_data",  128'(frame_data),  128'h000000F1_000000F2_000000F3_000000F4);
    check("s5_count", 128'(frame_count), 128'h1);
    check("s5_busy",  128'(busy),        128'h0);
    do_reset();
    #1;
    check("s5_rst_data",  128'(frame_data),  128'h0);
    check("s5_rst_count", 128'(frame_count), 128'h0);

    // Reset mid-payload, then a fresh frame (col 1 frame 0 -> bit 20).
    send(32'h0100_0200); send(32'h9999_0001); send(32'h9999_0002);
    do_reset();
    #1 check("s6_rst_busy", 128'(busy), 128'h0);
    send_frame(32'h0101_0000, 32'h21, 32'h22, 32'h23, 32'h24);
    #1;
    check("s6_strobe", 128'(frame_strobe), 128'(NS'(1) << 20));
    check("s6_count",  128'(frame_count),  128'h1);
    idle(); idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
